// File: rtl/load_port_pkg.sv
// Shared types and width helpers for the load port receiver.
package load_port_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoading,
    StArmed,
    StRunning,
    StDone
  } state_e;

  function automatic int unsigned vaw_f(int unsigned num_variables);
    return $clog2(num_variables);
  endfunction

  function automatic int unsigned law_f(int unsigned num_variables);
    return $clog2(num_variables) + 1;
  endfunction

  function automatic int unsigned ct_width_f(int unsigned nsat, int unsigned num_variables,
                                             int unsigned max_membership);
    return law_f(num_variables) * (nsat - 1) * max_membership;
  endfunction

  function automatic int unsigned clause_width_f(int unsigned nsat, int unsigned num_variables);
    return nsat * law_f(num_variables);
  endfunction

endpackage

// File: rtl/load_port_receiver_if.sv
// Host-side load/start bundle: master is the load host, slave is the receiver.
interface load_port_receiver_if
  import load_port_pkg::*;
#(
  parameter int unsigned NSAT                      = 3,
  parameter int unsigned NUM_VARIABLES             = 2048,
  parameter int unsigned MAX_CLAUSE_MEMBERSHIP     = 20,
  parameter int unsigned UNSAT_CLAUSE_BUFFER_DEPTH = 2048
) ();

  localparam int unsigned VAW          = vaw_f(NUM_VARIABLES);
  localparam int unsigned LAW          = law_f(NUM_VARIABLES);
  localparam int unsigned UAW          = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH);
  localparam int unsigned CT_WIDTH     = ct_width_f(NSAT, NUM_VARIABLES, MAX_CLAUSE_MEMBERSHIP);
  localparam int unsigned CLAUSE_WIDTH = clause_width_f(NSAT, NUM_VARIABLES);

  logic                             att_load_valid;
  logic [LAW:0]                     att_load_addr;
  logic [VAW+MAX_CLAUSE_MEMBERSHIP-1:0] att_load_data;
  logic                             ct_load_valid;
  logic [VAW-1:0]                   ct_load_addr;
  logic [CT_WIDTH-1:0]              ct_load_data;
  logic                             ucb_load_valid;
  logic [UAW-1:0]                   ucb_load_addr;
  logic [CLAUSE_WIDTH-1:0]          ucb_load_data;
  logic                             load_end;
  logic                             cpu_start;

  modport master (
    output att_load_valid, att_load_addr, att_load_data,
    output ct_load_valid, ct_load_addr, ct_load_data,
    output ucb_load_valid, ucb_load_addr, ucb_load_data,
    output load_end, cpu_start
  );

  modport slave (
    input att_load_valid, att_load_addr, att_load_data,
    input ct_load_valid, ct_load_addr, ct_load_data,
    input ucb_load_valid, ucb_load_addr, ucb_load_data,
    input load_end, cpu_start
  );

endinterface

// File: rtl/ct_xor_fold.sv
// Folds a wide CT word into 32 bits by XOR of zero-padded 32-bit slices.
module ct_xor_fold #(
  parameter int unsigned Width = 480
) (
  input  logic [Width-1:0] data_i,
  output logic [31:0]      fold_o
);

  localparam int unsigned Slices = (Width + 31) / 32;

  logic [Slices*32-1:0] padded;

  always_comb begin
    padded              = '0;
    padded[Width-1:0]   = data_i;
    fold_o              = '0;
    for (int i = 0; i < Slices; i++) begin
      fold_o = fold_o ^ padded[i*32 +: 32];
    end
  end

endmodule

// File: rtl/load_port_receiver.sv
// Responder for the host load/start interface: registers load beats per thread and sequences runs.
// Optional CT checksum is built when LOAD_PORT_RX_CHECKSUM_EN is defined.
module load_port_receiver
  import load_port_pkg::*;
#(
  parameter int unsigned NSAT                      = 3,
  parameter int unsigned NUM_VARIABLES             = 2048,
  parameter int unsigned MAX_CLAUSE_MEMBERSHIP     = 20,
  parameter int unsigned UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
  parameter int unsigned NUM_THREADS               = 4,
  localparam int unsigned VAW          = vaw_f(NUM_VARIABLES),
  localparam int unsigned LAW          = law_f(NUM_VARIABLES),
  localparam int unsigned UAW          = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH),
  localparam int unsigned TW           = $clog2(NUM_THREADS),
  localparam int unsigned CT_WIDTH     = ct_width_f(NSAT, NUM_VARIABLES, MAX_CLAUSE_MEMBERSHIP),
  localparam int unsigned CLAUSE_WIDTH = clause_width_f(NSAT, NUM_VARIABLES),
  localparam int unsigned ATT_DW       = VAW + MAX_CLAUSE_MEMBERSHIP
) (
  input  logic                    clk,
  input  logic                    rst,
  load_port_receiver_if.slave     load_io,
  input  logic                    solver_done_i,
  output logic [TW-1:0]           thread_sel_o,
  output logic                    att_wr_en_o,
  output logic [LAW:0]            att_wr_addr_o,
  output logic [ATT_DW-1:0]       att_wr_data_o,
  output logic                    ct_wr_en_o,
  output logic [VAW-1:0]          ct_wr_addr_o,
  output logic [CT_WIDTH-1:0]     ct_wr_data_o,
  output logic                    ucb_setup_wr_en_o,
  output logic [UAW-1:0]          ucb_setup_wr_addr_o,
  output logic [CLAUSE_WIDTH-1:0] ucb_setup_wr_data_o,
  output logic                    ucb_setup_o,
  output logic                    start_o,
  output logic                    cpu_done,
  output logic                    proto_error_o,
  output logic [TW:0]             loaded_threads_o,
  output logic [31:0]             ct_checksum_o,
  output logic [31:0]             ct_checksum_last_o
);

  localparam logic [TW-1:0] LastThread = TW'(NUM_THREADS - 1);

  state_e                  state_q;
  logic [TW-1:0]           thread_q;
  logic [TW:0]             loaded_q;
  logic [TW-1:0]           thread_sel_q;
  logic                    att_wr_en_q, ct_wr_en_q, ucb_wr_en_q;
  logic [LAW:0]            att_wr_addr_q;
  logic [ATT_DW-1:0]       att_wr_data_q;
  logic [VAW-1:0]          ct_wr_addr_q;
  logic [CT_WIDTH-1:0]     ct_wr_data_q;
  logic [UAW-1:0]          ucb_wr_addr_q;
  logic [CLAUSE_WIDTH-1:0] ucb_wr_data_q;
  logic                    ucb_setup_q, start_q, done_q, err_q;

  logic any_valid;
  logic loading_ok;

  assign any_valid  = load_io.att_load_valid | load_io.ct_load_valid | load_io.ucb_load_valid;
  assign loading_ok = (state_q == StIdle) || (state_q == StLoading);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      thread_q      <= '0;
      loaded_q      <= '0;
      thread_sel_q  <= '0;
      att_wr_en_q   <= 1'b0;
      att_wr_addr_q <= '0;
      att_wr_data_q <= '0;
      ct_wr_en_q    <= 1'b0;
      ct_wr_addr_q  <= '0;
      ct_wr_data_q  <= '0;
      ucb_wr_en_q   <= 1'b0;
      ucb_wr_addr_q <= '0;
      ucb_wr_data_q <= '0;
      ucb_setup_q   <= 1'b1;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      att_wr_en_q <= 1'b0;
      ct_wr_en_q  <= 1'b0;
      ucb_wr_en_q <= 1'b0;
      start_q     <= 1'b0;
      // Lags the state by one cycle so setup stays asserted through the closing load_end.
      ucb_setup_q <= loading_ok;

      case (state_q)
        StIdle, StLoading: begin
          if (load_io.att_load_valid) begin
            att_wr_en_q   <= 1'b1;
            att_wr_addr_q <= load_io.att_load_addr;
            att_wr_data_q <= load_io.att_load_data;
          end
          if (load_io.ct_load_valid) begin
            ct_wr_en_q   <= 1'b1;
            ct_wr_addr_q <= load_io.ct_load_addr;
            ct_wr_data_q <= load_io.ct_load_data;
          end
          if (load_io.ucb_load_valid) begin
            ucb_wr_en_q   <= 1'b1;
            ucb_wr_addr_q <= load_io.ucb_load_addr;
            ucb_wr_data_q <= load_io.ucb_load_data;
          end
          if (any_valid) begin
            thread_sel_q <= thread_q;
            state_q      <= StLoading;
          end
          // Beats in the same cycle as load_end are tagged with the pre-increment thread.
          if (load_io.load_end) begin
            loaded_q <= loaded_q + (TW + 1)'(1);
            if (thread_q == LastThread) begin
              state_q <= StArmed;
            end else begin
              thread_q <= thread_q + TW'(1);
              state_q  <= StLoading;
            end
          end
          if (load_io.cpu_start) err_q <= 1'b1;
        end
        StArmed: begin
          if (any_valid || load_io.load_end) err_q <= 1'b1;
          if (load_io.cpu_start) begin
            start_q <= 1'b1;
            state_q <= StRunning;
          end
        end
        StRunning: begin
          if (any_valid || load_io.load_end || load_io.cpu_start) err_q <= 1'b1;
          if (solver_done_i) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (any_valid || load_io.load_end) err_q <= 1'b1;
          if (load_io.cpu_start) begin
            start_q <= 1'b1;
            done_q  <= 1'b0;
            state_q <= StRunning;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign thread_sel_o        = thread_sel_q;
  assign att_wr_en_o         = att_wr_en_q;
  assign att_wr_addr_o       = att_wr_addr_q;
  assign att_wr_data_o       = att_wr_data_q;
  assign ct_wr_en_o          = ct_wr_en_q;
  assign ct_wr_addr_o        = ct_wr_addr_q;
  assign ct_wr_data_o        = ct_wr_data_q;
  assign ucb_setup_wr_en_o   = ucb_wr_en_q;
  assign ucb_setup_wr_addr_o = ucb_wr_addr_q;
  assign ucb_setup_wr_data_o = ucb_wr_data_q;
  assign ucb_setup_o         = ucb_setup_q;
  assign start_o             = start_q;
  assign cpu_done            = done_q;
  assign proto_error_o       = err_q;
  assign loaded_threads_o    = loaded_q;

`ifdef LOAD_PORT_RX_CHECKSUM_EN
  logic [31:0] fold;
  logic [31:0] csum_q, csum_d;
  logic [31:0] csum_last_q;

  ct_xor_fold #(
    .Width(CT_WIDTH)
  ) u_ct_xor_fold (
    .data_i(load_io.ct_load_data),
    .fold_o(fold)
  );

  always_comb begin
    csum_d = csum_q;
    if (loading_ok && load_io.ct_load_valid) csum_d = csum_q ^ fold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q      <= '0;
      csum_last_q <= '0;
    end else if (loading_ok && load_io.load_end) begin
      csum_last_q <= csum_d;
      csum_q      <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign ct_checksum_o      = csum_q;
  assign ct_checksum_last_o = csum_last_q;
`else
  assign ct_checksum_o      = '0;
  assign ct_checksum_last_o = '0;
`endif

endmodule

// File: tb/tb_load_port_receiver.sv
// Directed bench for load_port_receiver: vector table plus multi-cycle sequences.
module tb_load_port_receiver;
  import load_port_pkg::*;

  localparam int unsigned CTW = 480;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic solver_done_i = 1'b0;

  logic [1:0]   thread_sel_o;
  logic         att_wr_en_o, ct_wr_en_o, ucb_setup_wr_en_o;
  logic [12:0]  att_wr_addr_o;
  logic [30:0]  att_wr_data_o;
  logic [10:0]  ct_wr_addr_o;
  logic [CTW-1:0] ct_wr_data_o;
  logic [10:0]  ucb_setup_wr_addr_o;
  logic [35:0]  ucb_setup_wr_data_o;
  logic         ucb_setup_o, start_o, cpu_done, proto_error_o;
  logic [2:0]   loaded_threads_o;
  logic [31:0]  ct_checksum_o, ct_checksum_last_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_port_receiver_if lif ();

  load_port_receiver dut (
    .clk                 (clk),
    .rst                 (rst),
    .load_io             (lif),
    .solver_done_i       (solver_done_i),
    .thread_sel_o        (thread_sel_o),
    .att_wr_en_o         (att_wr_en_o),
    .att_wr_addr_o       (att_wr_addr_o),
    .att_wr_data_o       (att_wr_data_o),
    .ct_wr_en_o          (ct_wr_en_o),
    .ct_wr_addr_o        (ct_wr_addr_o),
    .ct_wr_data_o        (ct_wr_data_o),
    .ucb_setup_wr_en_o   (ucb_setup_wr_en_o),
    .ucb_setup_wr_addr_o (ucb_setup_wr_addr_o),
    .ucb_setup_wr_data_o (ucb_setup_wr_data_o),
    .ucb_setup_o         (ucb_setup_o),
    .start_o             (start_o),
    .cpu_done            (cpu_done),
    .proto_error_o       (proto_error_o),
    .loaded_threads_o    (loaded_threads_o),
    .ct_checksum_o       (ct_checksum_o),
    .ct_checksum_last_o  (ct_checksum_last_o)
  );

  typedef struct {
    logic       att, ct, ucb, le, cs, sd;
    logic [10:0] addr;
    logic       e_att, e_ct, e_ucb;
    logic [1:0] e_tsel;
    logic       e_start, e_done, e_err;
    logic [2:0] e_loaded;
    logic       e_setup;
    logic [10:0] e_ct_addr;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic att, ct, ucb, le, cs, sd, input int addr,
                              input logic e_att, e_ct, e_ucb, input int e_tsel,
                              input logic e_start, e_done, e_err, input int e_loaded,
                              input logic e_setup, input int e_ct_addr);
    vec_t v;
    v.att = att; v.ct = ct; v.ucb = ucb; v.le = le; v.cs = cs; v.sd = sd;
    v.addr = 11'(addr);
    v.e_att = e_att; v.e_ct = e_ct; v.e_ucb = e_ucb; v.e_tsel = 2'(e_tsel);
    v.e_start = e_start; v.e_done = e_done; v.e_err = e_err;
    v.e_loaded = 3'(e_loaded); v.e_setup = e_setup; v.e_ct_addr = 11'(e_ct_addr);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    lif.att_load_valid = 1'b0; lif.att_load_addr = '0; lif.att_load_data = '0;
    lif.ct_load_valid  = 1'b0; lif.ct_load_addr  = '0; lif.ct_load_data  = '0;
    lif.ucb_load_valid = 1'b0; lif.ucb_load_addr = '0; lif.ucb_load_data = '0;
    lif.load_end = 1'b0; lif.cpu_start = 1'b0; solver_done_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    clr_in();
    vecs[0]  = mk(1,0,0,0,0,0, 5, 1,0,0, 0, 0,0,0, 0, 1, 0);
    vecs[1]  = mk(1,1,1,0,0,0, 6, 1,1,1, 0, 0,0,0, 0, 1, 6);
    vecs[2]  = mk(0,0,0,1,0,0, 0, 0,0,0, 0, 0,0,0, 1, 1, 6);
    vecs[3]  = mk(0,1,0,1,0,0, 7, 0,1,0, 1, 0,0,0, 2, 1, 7);
    vecs[4]  = mk(0,1,0,1,0,0, 8, 0,1,0, 2, 0,0,0, 3, 1, 8);
    vecs[5]  = mk(0,1,0,0,0,0, 9, 0,1,0, 3, 0,0,0, 3, 1, 9);
    vecs[6]  = mk(0,0,0,1,0,0, 0, 0,0,0, 3, 0,0,0, 4, 1, 9);
    vecs[7]  = mk(0,0,0,0,0,0, 0, 0,0,0, 3, 0,0,0, 4, 0, 9);
    vecs[8]  = mk(0,0,0,0,1,0, 0, 0,0,0, 3, 1,0,0, 4, 0, 9);
    vecs[9]  = mk(0,0,0,0,0,0, 0, 0,0,0, 3, 0,0,0, 4, 0, 9);
    vecs[10] = mk(0,1,0,0,0,0,10, 0,0,0, 3, 0,0,1, 4, 0, 9);
    vecs[11] = mk(0,0,0,0,0,1, 0, 0,0,0, 3, 0,1,1, 4, 0, 9);
    vecs[12] = mk(0,0,0,0,0,0, 0, 0,0,0, 3, 0,1,1, 4, 0, 9);
    vecs[13] = mk(0,0,0,0,1,0, 0, 0,0,0, 3, 1,0,1, 4, 0, 9);
    vecs[14] = mk(0,0,0,0,0,0, 0, 0,0,0, 3, 0,0,1, 4, 0, 9);

    // Reset state
    do_reset();
    chk("rst_tsel", 64'(thread_sel_o), 0);
    chk("rst_ct_en", 64'(ct_wr_en_o), 0);
    chk("rst_att_en", 64'(att_wr_en_o), 0);
    chk("rst_ucb_en", 64'(ucb_setup_wr_en_o), 0);
    chk("rst_setup", 64'(ucb_setup_o), 1);
    chk("rst_start", 64'(start_o), 0);
    chk("rst_done", 64'(cpu_done), 0);
    chk("rst_err", 64'(proto_error_o), 0);
    chk("rst_loaded", 64'(loaded_threads_o), 0);
    chk("rst_csum", 64'(ct_checksum_o), 0);

    // Vector table: full load/run/rerun flow
    for (int i = 0; i < 15; i++) begin
      clr_in();
      lif.att_load_valid = vecs[i].att;
      lif.att_load_addr  = 13'(vecs[i].addr);
      lif.att_load_data  = 31'(vecs[i].addr) + 31'h100;
      lif.ct_load_valid  = vecs[i].ct;
      lif.ct_load_addr   = vecs[i].addr;
      lif.ct_load_data   = CTW'(vecs[i].addr);
      lif.ucb_load_valid = vecs[i].ucb;
      lif.ucb_load_addr  = vecs[i].addr;
      lif.ucb_load_data  = 36'(vecs[i].addr);
      lif.load_end       = vecs[i].le;
      lif.cpu_start      = vecs[i].cs;
      solver_done_i      = vecs[i].sd;
      step();
      chk($sformatf("v%0d_att_en", i), 64'(att_wr_en_o), 64'(vecs[i].e_att));
      chk($sformatf("v%0d_ct_en", i), 64'(ct_wr_en_o), 64'(vecs[i].e_ct));
      chk($sformatf("v%0d_ucb_en", i), 64'(ucb_setup_wr_en_o), 64'(vecs[i].e_ucb));
      chk($sformatf("v%0d_tsel", i), 64'(thread_sel_o), 64'(vecs[i].e_tsel));
      chk($sformatf("v%0d_start", i), 64'(start_o), 64'(vecs[i].e_start));
      chk($sformatf("v%0d_done", i), 64'(cpu_done), 64'(vecs[i].e_done));
      chk($sformatf("v%0d_err", i), 64'(proto_error_o), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_loaded", i), 64'(loaded_threads_o), 64'(vecs[i].e_loaded));
      chk($sformatf("v%0d_setup", i), 64'(ucb_setup_o), 64'(vecs[i].e_setup));
      chk($sformatf("v%0d_ct_addr", i), 64'(ct_wr_addr_o), 64'(vecs[i].e_ct_addr));
      if (i == 0) begin
        chk("v0_att_addr", 64'(att_wr_addr_o), 5);
        chk("v0_att_data", 64'(att_wr_data_o), 64'h105);
      end
      if (i == 1) begin
        chk("v1_ucb_addr", 64'(ucb_setup_wr_addr_o), 6);
        chk("v1_ucb_data", 64'(ucb_setup_wr_data_o), 6);
      end
    end

    // cpu_start during LOADING is dropped and flagged
    do_reset();
    lif.ct_load_valid = 1'b1; lif.ct_load_addr = 11'd3;
    step();
    clr_in();
    lif.cpu_start = 1'b1;
    step();
    chk("ld_cs_start", 64'(start_o), 0);
    chk("ld_cs_err", 64'(proto_error_o), 1);
    clr_in();
    step();
    chk("ld_cs_start2", 64'(start_o), 0);

    // rst mid-load aborts back to IDLE with counters cleared
    lif.load_end = 1'b1;
    step();
    step();
    chk("midld_loaded2", 64'(loaded_threads_o), 2);
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_loaded", 64'(loaded_threads_o), 0);
    chk("midrst_setup", 64'(ucb_setup_o), 1);
    chk("midrst_err", 64'(proto_error_o), 0);
    lif.ct_load_valid = 1'b1; lif.ct_load_addr = 11'd4;
    step();
    chk("midrst_tsel", 64'(thread_sel_o), 0);
    chk("midrst_ct_en", 64'(ct_wr_en_o), 1);

    // Full 2048-beat CT load on each of four threads
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 2048; a++) begin
        clr_in();
        lif.ct_load_valid = 1'b1;
        lif.ct_load_addr  = 11'(a);
        lif.ct_load_data  = CTW'(a);
        step();
        if (ct_wr_en_o !== 1'b1 || ct_wr_addr_o !== 11'(a) || ct_wr_data_o !== CTW'(a)
            || thread_sel_o !== 2'(t)) begin
          chk($sformatf("bulk_t%0d_a%0d", t, a),
              {31'd0, ct_wr_en_o, 8'(thread_sel_o), 13'd0, ct_wr_addr_o},
              {31'd0, 1'b1, 8'(t), 13'd0, 11'(a)});
        end else begin
          total++;
        end
      end
      clr_in();
      lif.load_end = 1'b1;
      step();
      chk($sformatf("bulk_loaded_t%0d", t), 64'(loaded_threads_o), 64'(t + 1));
    end
    clr_in();
    step();
    chk("bulk_setup_drop", 64'(ucb_setup_o), 0);
    chk("bulk_err", 64'(proto_error_o), 0);
    lif.cpu_start = 1'b1;
    step();
    chk("bulk_start", 64'(start_o), 1);
    clr_in();
    step();
    chk("bulk_start_once", 64'(start_o), 0);
    solver_done_i = 1'b1;
    step();
    chk("bulk_done", 64'(cpu_done), 1);
    clr_in();

`ifdef LOAD_PORT_RX_CHECKSUM_EN
    do_reset();
    lif.ct_load_valid = 1'b1;
    lif.ct_load_data  = '1;
    step();
    chk("csum_ones1", 64'(ct_checksum_o), 64'hFFFF_FFFF);
    step();
    chk("csum_ones2", 64'(ct_checksum_o), 0);
    lif.ct_load_data = CTW'(32'hA5A5_A5A5);
    step();
    chk("csum_a5", 64'(ct_checksum_o), 64'hA5A5_A5A5);
    clr_in();
    lif.load_end = 1'b1;
    step();
    chk("csum_last", 64'(ct_checksum_last_o), 64'hA5A5_A5A5);
    chk("csum_clr", 64'(ct_checksum_o), 0);
    clr_in();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
